uart_reg_master: RTL

//  Host-side UART register-access initiator for the FM transmitter's UART register interface.

---
 rtl/fm_uart_pkg.sv | 54 +++++
 rtl/uart_rx_byte.sv | 119 +++++++++++
 rtl/uart_reg_master.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/fm_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fm_uart_pkg
//  Description : Shared constants, state encodings and a command-frame helper
//                for the UART register-access master.
//  Revision    : 1.0 - initial release
// ============================================================================
package fm_uart_pkg;

   // Command opcodes, the first byte of every command frame
   localparam logic [7:0] CMD_WR = 8'h57;
   localparam logic [7:0] CMD_RD = 8'h52;

   // Frame lengths in bytes
   localparam int WR_BYTES  = 5;
   localparam int RD_BYTES  = 3;
   localparam int RSP_BYTES = 2;

   // One 8N1 character: start + 8 data + stop
   localparam int FRAME_BITS = 10;

   // Master transaction states
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SEND     = 2'd1,
      ST_WAIT_RSP = 2'd2,
      ST_DONE     = 2'd3
   } mst_state_t;

   // Receiver states
   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   // Byte idx of the command frame for the latched request
   function automatic logic [7:0] cmd_byte(input logic        wr,
                                           input logic [15:0] addr,
                                           input logic [15:0] wdata,
                                           input logic [2:0]  idx);
      case (idx)
         3'd0:    cmd_byte = wr ? CMD_WR : CMD_RD;
         3'd1:    cmd_byte = addr[15:8];
         3'd2:    cmd_byte = addr[7:0];
         3'd3:    cmd_byte = wdata[15:8];
         3'd4:    cmd_byte = wdata[7:0];
         default: cmd_byte = 8'hFF;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_byte
//  Description : 8N1 UART byte receiver with 2-FF input synchronizer,
//                mid-bit start-glitch rejection and mid-bit data sampling.
//                o_byte_valid pulses for every completed character;
//                o_frame_err qualifies it when the stop bit sampled low.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_byte
   import fm_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_rx,
   output logic [7:0] o_byte,
   output logic       o_byte_valid,
   output logic       o_frame_err
);

   localparam int             CNT_W   = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

   logic             sync1;
   logic             sync2;
   logic             sync3;
   logic             fall;
   rx_state_t        state;
   rx_state_t        state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shreg;

   // Line idles high, so the falling edge of the synchronized line marks a start bit
   assign fall = sync3 & ~sync2;

   // Two-flop synchronizer plus one extra stage for edge detection
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         sync3 <= 1'b1;
      end else begin
         sync1 <= i_rx;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   // Receiver state register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= RX_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Receiver next-state: a start bit that is high again at mid-bit is a glitch
   always_comb begin
      state_nxt = state;
      case (state)
         RX_IDLE:  if (fall) state_nxt = RX_START;
         RX_START: if (cnt == HALF_M1) state_nxt = sync2 ? RX_IDLE : RX_DATA;
         RX_DATA:  if ((cnt == FULL_M1) && (bit_idx == 3'd7)) state_nxt = RX_STOP;
         RX_STOP:  if (cnt == FULL_M1) state_nxt = RX_IDLE;
         default:  state_nxt = RX_IDLE;
      endcase
   end

   // Bit timing, LSB-first shift and byte completion strobes
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt          <= '0;
         bit_idx      <= 3'd0;
         shreg        <= 8'h00;
         o_byte       <= 8'h00;
         o_byte_valid <= 1'b0;
         o_frame_err  <= 1'b0;
      end else begin
         o_byte_valid <= 1'b0;
         o_frame_err  <= 1'b0;
         case (state)
            RX_IDLE: begin
               cnt     <= '0;
               bit_idx <= 3'd0;
            end
            RX_START: begin
               cnt <= (cnt == HALF_M1) ? '0 : cnt + 1'b1;
            end
            RX_DATA: begin
               if (cnt == FULL_M1) begin
                  cnt     <= '0;
                  shreg   <= {sync2, shreg[7:1]};
                  bit_idx <= bit_idx + 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RX_STOP: begin
               if (cnt == FULL_M1) begin
                  cnt          <= '0;
                  o_byte       <= shreg;
                  o_byte_valid <= 1'b1;
                  o_frame_err  <= ~sync2;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: cnt <= '0;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_reg_master.sv
`default_nettype none
// ============================================================================
//  Module      : uart_reg_master
//  Description : Host-side UART register-access initiator. Serializes a
//                parallel read/write request into an 8N1 command frame and,
//                for reads, collects the two-byte reply or times out.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_reg_master
   import fm_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int TIMEOUT_CLKS = 50000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_wr,
   input  logic [15:0] i_req_addr,
   input  logic [15:0] i_req_wdata,
   output logic        o_rsp_valid,
   output logic [15:0] o_rsp_rdata,
   output logic        o_rsp_timeout,
   output logic        o_busy,
   output logic        o_uart_mosi,
   input  logic        i_uart_miso
);

   localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
   localparam int                TMO_W     = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CLKS - 1);
   localparam logic [3:0]        STOP_BIT  = 4'(FRAME_BITS - 1);

   mst_state_t        state;
   mst_state_t        state_nxt;

   logic              req_wr;
   logic [15:0]       req_addr;
   logic [15:0]       req_wdata;
   logic [2:0]        byte_idx;
   logic [3:0]        bit_idx;
   logic [BAUD_W-1:0] baud_cnt;
   logic [TMO_W-1:0]  tmo_cnt;
   logic              got_hi;
   logic [7:0]        rsp_hi;
   logic              tx_line;

   logic [7:0]        rx_byte;
   logic              rx_valid;
   logic              rx_err;

   logic              handshake;
   logic [2:0]        last_byte;
   logic [7:0]        cur_byte;
   logic              bit_end;
   logic              byte_end;
   logic              frame_end;
   logic              good_byte;
   logic              rsp_complete;
   logic              tmo_expired;

   uart_rx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_rx (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_rx         (i_uart_miso),
      .o_byte       (rx_byte),
      .o_byte_valid (rx_valid),
      .o_frame_err  (rx_err)
   );

   assign o_uart_mosi  = tx_line;
   assign handshake    = (state == ST_IDLE) && i_req_valid;
   assign last_byte    = req_wr ? 3'(WR_BYTES - 1) : 3'(RD_BYTES - 1);
   assign cur_byte     = cmd_byte(req_wr, req_addr, req_wdata, byte_idx);
   assign bit_end      = (state == ST_SEND) && (baud_cnt == BAUD_LAST);
   assign byte_end     = bit_end && (bit_idx == STOP_BIT);
   assign frame_end    = byte_end && (byte_idx == last_byte);
   // Bytes with a bad stop bit, or arriving outside WAIT_RSP, are ignored
   assign good_byte    = (state == ST_WAIT_RSP) && rx_valid && !rx_err;
   assign rsp_complete = good_byte && got_hi;
   // A byte landing in the expiry cycle takes precedence over the timeout
   assign tmo_expired  = (state == ST_WAIT_RSP) && !good_byte && (tmo_cnt == TMO_LAST);

   // Transaction state register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Transaction next-state and handshake/status outputs
   always_comb begin
      state_nxt   = state;
      o_req_ready = 1'b0;
      o_busy      = 1'b1;
      o_rsp_valid = 1'b0;
      case (state)
         ST_IDLE: begin
            o_req_ready = 1'b1;
            o_busy      = 1'b0;
            if (handshake) state_nxt = ST_SEND;
         end
         ST_SEND: begin
            if (frame_end) state_nxt = req_wr ? ST_DONE : ST_WAIT_RSP;
         end
         ST_WAIT_RSP: begin
            if (rsp_complete || tmo_expired) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            o_rsp_valid = 1'b1;
            state_nxt   = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Request latch, TX shifter, reply collection and timeout counter
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         req_wr        <= 1'b0;
         req_addr      <= 16'h0000;
         req_wdata     <= 16'h0000;
         byte_idx      <= 3'd0;
         bit_idx       <= 4'd0;
         baud_cnt      <= '0;
         tmo_cnt       <= '0;
         got_hi        <= 1'b0;
         rsp_hi        <= 8'h00;
         tx_line       <= 1'b1;
         o_rsp_rdata   <= 16'h0000;
         o_rsp_timeout <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (handshake) begin
                  req_wr    <= i_req_wr;
                  req_addr  <= i_req_addr;
                  req_wdata <= i_req_wdata;
                  byte_idx  <= 3'd0;
                  bit_idx   <= 4'd0;
                  baud_cnt  <= '0;
                  tx_line   <= 1'b0;
               end
            end
            ST_SEND: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (byte_end) begin
                     bit_idx <= 4'd0;
                     if (frame_end) begin
                        tx_line <= 1'b1;
                        tmo_cnt <= '0;
                        got_hi  <= 1'b0;
                        if (req_wr) o_rsp_timeout <= 1'b0;
                     end else begin
                        byte_idx <= byte_idx + 1'b1;
                        tx_line  <= 1'b0;
                     end
                  end else begin
                     // Bit idx (0..7) of the next slot is data bit idx; slot 9 is stop
                     bit_idx <= bit_idx + 1'b1;
                     tx_line <= (bit_idx < 4'd8) ? cur_byte[bit_idx[2:0]] : 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            ST_WAIT_RSP: begin
               if (good_byte) begin
                  tmo_cnt <= '0;
                  if (got_hi) begin
                     o_rsp_rdata   <= {rsp_hi, rx_byte};
                     o_rsp_timeout <= 1'b0;
                  end else begin
                     rsp_hi <= rx_byte;
                     got_hi <= 1'b1;
                  end
               end else if (tmo_expired) begin
                  o_rsp_rdata   <= 16'h0000;
                  o_rsp_timeout <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            default: begin
               tx_line <= 1'b1;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
